// File: rtl/bomb_pkg.sv
// Shared constants and state encodings for the bomb game blocks.
// Imported by the display, controller and sequence checker.
package bomb_pkg;

  localparam logic [7:0] ARM_STATE = 8'h10;

  localparam logic [3:0] CODE_0 = 4'b1110;
  localparam logic [3:0] CODE_1 = 4'b1101;
  localparam logic [3:0] CODE_2 = 4'b1011;
  localparam logic [3:0] CODE_3 = 4'b0111;

  typedef enum logic [1:0] {
    IDLE,
    SHOW,
    COLLECT,
    RESULT
  } chk_state_t;

  function automatic logic [3:0] seq_nibble(
    input logic [15:0] seq,
    input logic [1:0]  idx
  );
    logic [3:0] n;
    unique case (idx)
      2'd0: n = seq[15:12];
      2'd1: n = seq[11:8];
      2'd2: n = seq[7:4];
      default: n = seq[3:0];
    endcase
    return n;
  endfunction

endpackage

// File: rtl/sec_countdown.sv
// Loadable seconds countdown with expiry flag on the 1 -> 0 step.
// Shared by the sequence checker and the global bomb timer.
module sec_countdown #(
  parameter int LIMIT = 30,
  parameter int W     = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic         tick,
  output logic [W-1:0] count,
  output logic         expire
);

  assign expire = en && tick && (count == W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= W'(LIMIT);
    end else if (load) begin
      count <= W'(LIMIT);
    end else if (en && tick && count != '0) begin
      count <= count - W'(1);
    end
  end

endmodule

// File: rtl/sequence_checker.sv
// Latches the shown sequence, collects four user digits under a
// time limit, and reports pass/fail plus saturating strikes.
import bomb_pkg::*;

module sequence_checker #(
  parameter int SHOW_SECS   = 3,
  parameter int TIME_LIMIT  = 30,
  parameter int MAX_STRIKES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  game_state,
  input  logic [15:0] sequence_in,
  input  logic [3:0]  user_code,
  input  logic        button_next,
  input  logic        one_sec,
  output logic [1:0]  digit_idx,
  output logic [5:0]  time_left,
  output logic        result_valid,
  output logic        result_pass,
  output logic [1:0]  strikes,
  output logic        exploded
);

  chk_state_t  state, state_nx;
  logic [15:0] expected, expected_nx;
  logic        err, err_nx;
  logic [7:0]  sec_cnt, sec_cnt_nx;
  logic [1:0]  digit_idx_nx;
  logic        result_pass_nx;
  logic [1:0]  strikes_nx;
  logic        arm_prev;
  logic        arm_lvl;
  logic        arm_evt;
  logic        cd_load;
  logic        cd_en;
  logic        timeout;
  logic        mism;

  assign arm_lvl      = (game_state == ARM_STATE);
  assign arm_evt      = arm_lvl && !arm_prev;
  assign exploded     = (strikes == 2'(MAX_STRIKES));
  assign result_valid = (state == RESULT);
  assign mism = (user_code != seq_nibble(expected, digit_idx));

  sec_countdown #(
    .LIMIT (TIME_LIMIT),
    .W     (6)
  ) u_timer (
    .clk    (clk),
    .rst_n  (reset),
    .load   (cd_load),
    .en     (cd_en),
    .tick   (one_sec),
    .count  (time_left),
    .expire (timeout)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      expected    <= 16'hFFFF;
      err         <= 1'b0;
      sec_cnt     <= '0;
      digit_idx   <= '0;
      result_pass <= 1'b0;
      strikes     <= '0;
      arm_prev    <= 1'b0;
    end else begin
      state       <= state_nx;
      expected    <= expected_nx;
      err         <= err_nx;
      sec_cnt     <= sec_cnt_nx;
      digit_idx   <= digit_idx_nx;
      result_pass <= result_pass_nx;
      strikes     <= strikes_nx;
      arm_prev    <= arm_lvl;
    end
  end

  always_comb begin
    state_nx       = state;
    expected_nx    = expected;
    err_nx         = err;
    sec_cnt_nx     = sec_cnt;
    digit_idx_nx   = digit_idx;
    result_pass_nx = result_pass;
    strikes_nx     = strikes;
    cd_load        = 1'b0;
    cd_en          = 1'b0;
    unique case (state)
      IDLE: begin
        if (arm_evt && !exploded) begin
          expected_nx  = sequence_in;
          sec_cnt_nx   = '0;
          err_nx       = 1'b0;
          digit_idx_nx = '0;
          cd_load      = 1'b1;
          state_nx     = SHOW;
        end
      end
      SHOW: begin
        if (sec_cnt == 8'(SHOW_SECS)) begin
          state_nx = COLLECT;
        end else if (one_sec) begin
          sec_cnt_nx = sec_cnt + 8'd1;
        end
      end
      COLLECT: begin
        cd_en = 1'b1;
        // Expiry beats a same-cycle confirm.
        if (timeout) begin
          result_pass_nx = 1'b0;
          state_nx       = RESULT;
        end else if (button_next) begin
          err_nx       = err || mism;
          digit_idx_nx = digit_idx + 2'd1;
          if (digit_idx == 2'd3) begin
            result_pass_nx = !(err || mism);
            state_nx       = RESULT;
          end
        end
      end
      RESULT: begin
        state_nx = IDLE;
        if (!result_pass && !exploded) begin
          strikes_nx = strikes + 2'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sequence_checker.sv
// Directed bench for sequence_checker: rounds, timeouts,
// strike saturation, arm edge detection and async reset.
module tb_sequence_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  game_state;
  logic [15:0] sequence_in;
  logic [3:0]  user_code;
  logic        button_next;
  logic        one_sec;
  logic [1:0]  digit_idx;
  logic [5:0]  time_left;
  logic        result_valid;
  logic        result_pass;
  logic [1:0]  strikes;
  logic        exploded;

  int vectors = 0;
  int miscompares = 0;

  sequence_checker dut (
    .clk          (clk),
    .reset        (reset),
    .game_state   (game_state),
    .sequence_in  (sequence_in),
    .user_code    (user_code),
    .button_next  (button_next),
    .one_sec      (one_sec),
    .digit_idx    (digit_idx),
    .time_left    (time_left),
    .result_valid (result_valid),
    .result_pass  (result_pass),
    .strikes      (strikes),
    .exploded     (exploded)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic sec1;
    one_sec = 1'b1;
    tick();
    one_sec = 1'b0;
  endtask

  task automatic conf(input logic [3:0] c);
    user_code   = c;
    button_next = 1'b1;
    tick();
    button_next = 1'b0;
  endtask

  task automatic arm(input logic [15:0] s, input bit hold);
    game_state  = 8'h10;
    sequence_in = s;
    tick();
    if (!hold) game_state = 8'h00;
  endtask

  task automatic show;
    repeat (3) sec1();
    tick();
  endtask

  initial begin
    reset       = 1'b0;
    game_state  = 8'h00;
    sequence_in = 16'h0000;
    user_code   = 4'h0;
    button_next = 1'b0;
    one_sec     = 1'b0;
    repeat (2) tick();
    chk("rst_idx", 32'(digit_idx), 32'd0);
    chk("rst_time", 32'(time_left), 32'd30);
    chk("rst_valid", 32'(result_valid), 32'd0);
    chk("rst_pass", 32'(result_pass), 32'd0);
    chk("rst_strk", 32'(strikes), 32'd0);
    chk("rst_expl", 32'(exploded), 32'd0);
    reset = 1'b1;
    tick();

    // Round 1: correct entry.
    arm(16'hE7BD, 1'b0);
    show();
    conf(4'hE);
    conf(4'h7);
    conf(4'hB);
    chk("r1_idx3", 32'(digit_idx), 32'd3);
    conf(4'hD);
    chk("r1_valid", 32'(result_valid), 32'd1);
    chk("r1_pass", 32'(result_pass), 32'd1);
    tick();
    chk("r1_vdrop", 32'(result_valid), 32'd0);
    chk("r1_strk", 32'(strikes), 32'd0);

    // Round 2: confirm during show ignored, wrong third digit.
    arm(16'hE7BD, 1'b0);
    conf(4'hE);
    chk("r2_showbtn", 32'(digit_idx), 32'd0);
    show();
    conf(4'hE);
    conf(4'h7);
    conf(4'hE);
    conf(4'hD);
    chk("r2_valid", 32'(result_valid), 32'd1);
    chk("r2_pass", 32'(result_pass), 32'd0);
    tick();
    chk("r2_strk", 32'(strikes), 32'd1);
    chk("r2_expl", 32'(exploded), 32'd0);

    // Round 3: timeout with arm level held high throughout.
    arm(16'hE7BD, 1'b1);
    show();
    conf(4'hE);
    conf(4'h7);
    repeat (29) sec1();
    chk("r3_t1", 32'(time_left), 32'd1);
    chk("r3_novalid", 32'(result_valid), 32'd0);
    sec1();
    chk("r3_valid", 32'(result_valid), 32'd1);
    chk("r3_pass", 32'(result_pass), 32'd0);
    chk("r3_t0", 32'(time_left), 32'd0);
    tick();
    chk("r3_vdrop", 32'(result_valid), 32'd0);
    chk("r3_strk", 32'(strikes), 32'd2);
    repeat (3) tick();
    chk("r3_norearm_t", 32'(time_left), 32'd0);
    chk("r3_norearm_i", 32'(digit_idx), 32'd2);
    game_state = 8'h00;
    tick();

    // Async reset in COLLECT with two strikes.
    arm(16'hE7BD, 1'b0);
    show();
    conf(4'hE);
    chk("ar_idx", 32'(digit_idx), 32'd1);
    chk("ar_strk", 32'(strikes), 32'd2);
    reset = 1'b0;
    #2;
    chk("ar_idx0", 32'(digit_idx), 32'd0);
    chk("ar_time", 32'(time_left), 32'd30);
    chk("ar_strk0", 32'(strikes), 32'd0);
    chk("ar_valid", 32'(result_valid), 32'd0);
    chk("ar_pass", 32'(result_pass), 32'd0);
    chk("ar_expl", 32'(exploded), 32'd0);
    #5;
    reset = 1'b1;
    tick();

    // Round 4: final second and confirm coincide.
    arm(16'hE7BD, 1'b0);
    show();
    conf(4'hE);
    repeat (29) sec1();
    user_code   = 4'h7;
    button_next = 1'b1;
    one_sec     = 1'b1;
    tick();
    button_next = 1'b0;
    one_sec     = 1'b0;
    chk("r4_valid", 32'(result_valid), 32'd1);
    chk("r4_pass", 32'(result_pass), 32'd0);
    chk("r4_idx", 32'(digit_idx), 32'd1);
    chk("r4_t0", 32'(time_left), 32'd0);
    tick();
    chk("r4_strk", 32'(strikes), 32'd1);

    // Round 5: wrong first digit.
    arm(16'hE7BD, 1'b0);
    show();
    conf(4'hD);
    conf(4'h7);
    conf(4'hB);
    conf(4'hD);
    chk("r5_pass", 32'(result_pass), 32'd0);
    tick();
    chk("r5_strk", 32'(strikes), 32'd2);

    // Round 6: third strike.
    arm(16'hD7BE, 1'b0);
    show();
    sec1();
    conf(4'hD);
    conf(4'h7);
    conf(4'hB);
    conf(4'hD);
    chk("r6_valid", 32'(result_valid), 32'd1);
    chk("r6_pass", 32'(result_pass), 32'd0);
    tick();
    chk("r6_strk", 32'(strikes), 32'd3);
    chk("r6_expl", 32'(exploded), 32'd1);

    // Arm after explosion must be ignored.
    arm(16'hE7BD, 1'b0);
    show();
    conf(4'hE);
    chk("ex_time", 32'(time_left), 32'd29);
    chk("ex_idx", 32'(digit_idx), 32'd0);
    chk("ex_valid", 32'(result_valid), 32'd0);
    chk("ex_expl", 32'(exploded), 32'd1);
    chk("ex_strk", 32'(strikes), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
